// File: rtl/vend_pkg.sv
// Shared vending-machine types: coin index, denomination values and dispenser states.
package vend_pkg;

    typedef logic [1:0] coin_idx_t;

    localparam int NUM_COINS = 4;

    // Denominations ordered largest first; the last one must be 1 so any remainder can be paid.
    localparam int COIN_VALUE [NUM_COINS] = '{25, 10, 5, 1};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EJECT,
        DONE
    } disp_state_t;

endpackage

// File: rtl/coin_selector.sv
// Combinational largest-fit picker: returns the lowest denomination index whose value fits in rem.
module coin_selector
    import vend_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COIN0 = COIN_VALUE[0],
    parameter int COIN1 = COIN_VALUE[1],
    parameter int COIN2 = COIN_VALUE[2],
    parameter int COIN3 = COIN_VALUE[3]
) (
    input  logic [WIDTH-1:0] rem,
    output coin_idx_t        sel,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] C0 = WIDTH'(COIN0);
    localparam logic [WIDTH-1:0] C1 = WIDTH'(COIN1);
    localparam logic [WIDTH-1:0] C2 = WIDTH'(COIN2);
    localparam logic [WIDTH-1:0] C3 = WIDTH'(COIN3);

    // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        sel   = 2'd3;
        value = C3;
        if (rem >= C0) begin
            sel   = 2'd0;
            value = C0;
        end else if (rem >= C1) begin
            sel   = 2'd1;
            value = C1;
        end else if (rem >= C2) begin
            sel   = 2'd2;
            value = C2;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: computes total-price and ejects it coin by coin, largest first,
// over a valid/ack handshake to the coin ejector.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COIN0 = COIN_VALUE[0],
    parameter int COIN1 = COIN_VALUE[1],
    parameter int COIN2 = COIN_VALUE[2],
    parameter int COIN3 = COIN_VALUE[3]
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] total_i,
    input  logic [WIDTH-1:0] price_i,
    input  logic             coin_ack_i,
    output logic             coin_vld_o,
    output logic [1:0]       coin_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] disp_cnt_o
);

    disp_state_t      state_q, state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] cnt_q;
    coin_idx_t        sel_q;
    logic             err_q;

    coin_idx_t        fit_sel;
    logic [WIDTH-1:0] fit_value;

    coin_selector #(
        .WIDTH (WIDTH),
        .COIN0 (COIN0),
        .COIN1 (COIN1),
        .COIN2 (COIN2),
        .COIN3 (COIN3)
    ) u_coin_selector (
        .rem   (rem_q),
        .sel   (fit_sel),
        .value (fit_value)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (total_i >= price_i) ? CALC : DONE;
            CALC:    state_d = (rem_q == '0) ? DONE : EJECT;
            EJECT:   if (coin_ack_i) state_d = CALC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q <= '0;
                        err_q <= (total_i < price_i);
                        rem_q <= (total_i >= price_i) ? (total_i - price_i) : '0;
                    end
                end
                CALC: begin
                    if (rem_q != '0) sel_q <= fit_sel;
                end
                EJECT: begin
                    // rem_q is frozen during EJECT, so fit_value still matches sel_q here.
                    if (coin_ack_i) begin
                        rem_q <= rem_q - fit_value;
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign coin_vld_o = (state_q == EJECT);
    assign coin_sel_o = sel_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = (state_q == DONE) && err_q;
    assign disp_cnt_o = cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy-division payout model.
module tb_change_dispenser;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] total_i = '0;
    logic [7:0] price_i = '0;
    logic       coin_ack_i = 1'b0;
    logic       coin_vld_o;
    logic [1:0] coin_sel_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] disp_cnt_o;

    change_dispenser dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .total_i    (total_i),
        .price_i    (price_i),
        .coin_ack_i (coin_ack_i),
        .coin_vld_o (coin_vld_o),
        .coin_sel_o (coin_sel_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .disp_cnt_o (disp_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    int coin_val [4] = '{25, 10, 5, 1};
    int exp_coins[$];
    int obs_coins[$];
    bit exp_err;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: change paid greedily by integer division per denomination.
    task automatic build_ref(input int total, input int price);
        int rem;
        exp_coins.delete();
        exp_err = (total < price);
        rem = exp_err ? 0 : total - price;
        for (int i = 0; i < 4; i++) begin
            int n;
            n = rem / coin_val[i];
            for (int k = 0; k < n; k++) exp_coins.push_back(i);
            rem = rem % coin_val[i];
        end
    endtask

    // Runs one transaction starting at a negedge; ends at the negedge after the done cycle.
    task automatic run_txn(input int total, input int price, input int ack_pct,
                           input int min_hold, input bit inject_start);
        int  cycle;
        int  done_cycle;
        int  vld_seen;
        int  wait_cnt;
        bit  pending;
        int  prev_sel;
        bit  stable_bad;
        bit  busy_bad;
        bit  done_seen;
        int  err_obs;
        int  cnt_at_done;

        build_ref(total, price);
        obs_coins.delete();
        cycle = 0; done_cycle = 0; vld_seen = 0; wait_cnt = 0;
        pending = 0; prev_sel = 0; stable_bad = 0; busy_bad = 0;
        done_seen = 0; err_obs = 0; cnt_at_done = 0;

        start_i = 1'b1;
        total_i = 8'(total);
        price_i = 8'(price);
        coin_ack_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        total_i = 8'($urandom_range(255));
        price_i = 8'($urandom_range(255));
        cycle = 1;

        while (cycle < 2000) begin
            if (done_o) begin
                done_seen   = 1;
                done_cycle  = cycle;
                err_obs     = int'(err_o);
                cnt_at_done = int'(disp_cnt_o);
                break;
            end
            if (!busy_o) busy_bad = 1;
            if (coin_vld_o) begin
                vld_seen++;
                if (pending && int'(coin_sel_o) != prev_sel) stable_bad = 1;
                prev_sel = int'(coin_sel_o);
                if (wait_cnt >= min_hold && $urandom_range(99) < ack_pct) begin
                    coin_ack_i = 1'b1;
                    obs_coins.push_back(int'(coin_sel_o));
                    pending  = 0;
                    wait_cnt = 0;
                end else begin
                    coin_ack_i = 1'b0;
                    pending  = 1;
                    wait_cnt++;
                end
            end else begin
                coin_ack_i = 1'($urandom_range(1));
                pending = 0;
            end
            if (inject_start) begin
                start_i = 1'($urandom_range(1));
                total_i = 8'($urandom_range(255));
                price_i = 8'($urandom_range(255));
            end
            @(negedge clk_i);
            cycle++;
        end

        start_i    = 1'b0;
        coin_ack_i = 1'b0;
        check($sformatf("done_reached t=%0d p=%0d", total, price), int'(done_seen), 1);
        check("err_flag", err_obs, int'(exp_err));
        check("coin_count", obs_coins.size(), exp_coins.size());
        for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++)
            check($sformatf("coin_sel[%0d]", i), obs_coins[i], exp_coins[i]);
        check("disp_cnt_at_done", cnt_at_done, exp_coins.size());
        check("sel_stable_while_waiting", int'(stable_bad), 0);
        check("busy_during_txn", int'(busy_bad), 0);
        if (exp_coins.size() == 0) begin
            check("no_coin_vld", vld_seen, 0);
            check("done_latency", done_cycle, exp_err ? 1 : 2);
        end

        @(negedge clk_i);
        check("done_single_pulse", int'(done_o), 0);
        check("err_single_pulse", int'(err_o), 0);
        check("idle_after_done", int'(busy_o), 0);
        check("disp_cnt_held", int'(disp_cnt_o), exp_coins.size());
    endtask

    task automatic reset_mid_eject();
        int guard;
        start_i = 1'b1;
        total_i = 8'd100;
        price_i = 8'd25;
        coin_ack_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        guard = 0;
        while (!coin_vld_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("vld_before_reset", int'(coin_vld_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_vld", int'(coin_vld_o), 0);
        check("rst_async_sel", int'(coin_sel_o), 0);
        check("rst_async_busy", int'(busy_o), 0);
        check("rst_async_done", int'(done_o), 0);
        check("rst_async_err", int'(err_o), 0);
        check("rst_async_cnt", int'(disp_cnt_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        run_txn(30, 25, 100, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_busy", int'(busy_o), 0);
        check("reset_vld", int'(coin_vld_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_cnt", int'(disp_cnt_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_txn(40, 25, 100, 0, 0);
        run_txn(25, 25, 100, 0, 0);
        run_txn(10, 25, 100, 0, 0);
        run_txn(255, 0, 100, 0, 0);
        run_txn(40, 25, 100, 5, 1);
        reset_mid_eject();

        for (int n = 0; n < 40; n++) begin
            int t;
            int p;
            t = $urandom_range(255);
            p = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(t);
            run_txn(t, p, 30 + $urandom_range(70), $urandom_range(2), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
